uart_tx_ctrl: RTL

Transmit-side controller for the UART 16550 core. It sits between the CPU register interface and the TX shift engine and does three jobs:
- buffers transmit bytes in a TX FIFO;
- generates the 16x-oversample `baud_pulse` from the divisor latch;
- drives `thre` and `din` and consumes the engine's `pop`, and raises the THRE interrupt.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_gen.sv | 45 ++++
 rtl/uart_tx_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit controller.
//   thre_int_state_t : THRE interrupt FSM state encoding
//   UART_DEF_DEPTH   : default TX FIFO depth
//   UART_DEF_DIV_W   : default divisor latch width
//   uart_occ_w()     : width of an occupancy count for a FIFO of given depth
package uart_pkg;

   typedef enum logic {
      INT_IDLE = 1'b0,
      INT_PEND = 1'b1
   } thre_int_state_t;

   localparam int UART_DEF_DEPTH = 16;
   localparam int UART_DEF_DIV_W = 16;

   // An occupancy counter must reach DEPTH itself, hence the extra bit.
   function automatic int uart_occ_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x-oversample baud tick generator.
// Ports:
//   clk        : core clock
//   rst        : synchronous active-high reset
//   divisor    : baud divisor {DLM,DLL}
//   baud_pulse : one-cycle tick every `divisor` clocks; high continuously
//                for divisor 1, never for divisor 0
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int DIV_W = UART_DEF_DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] divisor,
   output logic             baud_pulse
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_q;
   logic             div_chg;
   logic [DIV_W-1:0] reload;

   assign div_chg = (divisor != div_q);
   assign reload  = (divisor == '0) ? '0 : divisor - 1'b1;

   // div_q clears on reset, so the first cycle after release always looks
   // like a divisor change: that reload puts the first tick `divisor`
   // clocks after release.
   assign baud_pulse = ~rst & ~div_chg & (divisor != '0) & (cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         div_q <= '0;
      end else begin
         div_q <= divisor;
         if (div_chg || (cnt == '0))
            cnt <= reload;
         else
            cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART 16550 transmit-side controller: TX FIFO, baud tick, THRE status and
// THRE interrupt.
// Build option: UART_TX_FIFO_EN defined gives a DEPTH-entry FIFO (16550
// mode); undefined gives a single holding register (16450 mode) with a
// 1-bit level port.
// Ports:
//   clk, rst          : core clock, synchronous active-high reset
//   wr_en, wr_data    : THR write strobe and byte
//   fifo_clr          : TX FIFO reset pulse (overrides write/pop)
//   divisor           : baud divisor
//   ier_etbei, iir_rd : THRE interrupt enable, IIR read strobe
//   pop, sreg_empty   : from TX engine (pop: rising edge = byte taken)
//   baud_pulse        : baud tick
//   din               : FIFO head byte to engine
//   thre, temt        : FIFO empty; FIFO and shift register empty
//   fifo_full, overrun: FIFO full; sticky dropped-write flag
//   thre_int          : THRE interrupt request
//   level             : FIFO occupancy
//
// THRE interrupt FSM
//   state    | meaning
//   INT_IDLE | no THRE interrupt pending
//   INT_PEND | FIFO drained (or enable raised while empty); thre_int high
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_DEF_DEPTH,
   parameter int DIV_W = UART_DEF_DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [7:0]       wr_data,
   input  logic             fifo_clr,
   input  logic [DIV_W-1:0] divisor,
   input  logic             ier_etbei,
   input  logic             iir_rd,
   input  logic             pop,
   input  logic             sreg_empty,
   output logic             baud_pulse,
   output logic [7:0]       din,
   output logic             thre,
   output logic             temt,
   output logic             fifo_full,
   output logic             overrun,
   output logic             thre_int,
`ifdef UART_TX_FIFO_EN
   output logic [uart_occ_w(DEPTH)-1:0] level
`else
   output logic [0:0]       level
`endif
);

`ifdef UART_TX_FIFO_EN
   localparam int FD = DEPTH;
`else
   // Single holding register; DEPTH stays in the parameter list so both
   // builds instantiate identically.
   localparam int FD = DEPTH - DEPTH + 1;
`endif
   localparam int LW = uart_occ_w(FD);
   localparam int PW = (FD > 1) ? $clog2(FD) : 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(FD);
   localparam logic [LW-1:0] ONE_LVL  = LW'(1);
   localparam logic [PW-1:0] LAST_PTR = PW'(FD - 1);

   logic [7:0]      mem [FD];
   logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_inc, rd_ptr_inc;
   logic [LW-1:0]   level_nx;
   logic [7:0]      din_nx;
   logic            pop_q, ier_q;
   logic            pop_evt, pop_ok, wr_ok, wr_drop;
   logic            lvl_to_zero, int_set, int_clr;
   thre_int_state_t int_state;

   uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
      .clk        (clk),
      .rst        (rst),
      .divisor    (divisor),
      .baud_pulse (baud_pulse)
   );

   assign pop_evt    = pop & ~pop_q;
   assign fifo_full  = (level == FULL_LVL);
   assign thre       = (level == '0);
   assign temt       = thre & sreg_empty;
   assign pop_ok     = pop_evt & ~thre;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign wr_ok      = wr_en & (~fifo_full | pop_evt);
   assign wr_drop    = wr_en & ~wr_ok;
   assign rd_ptr_inc = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
   assign wr_ptr_inc = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;

   always_comb begin
      level_nx = level;
      if (wr_ok && !pop_ok)
         level_nx = level + 1'b1;
      else if (pop_ok && !wr_ok)
         level_nx = level - 1'b1;
   end

   // din is the head entry after this cycle's update. When the last entry
   // is popped while a write lands, the write is the new head and is not
   // in mem yet, so it is forwarded from wr_data.
   always_comb begin
      din_nx = din;
      if (pop_ok) begin
         if (level == ONE_LVL) begin
            if (wr_ok)
               din_nx = wr_data;
         end else begin
            din_nx = mem[rd_ptr_inc];
         end
      end else if (wr_ok && thre) begin
         din_nx = wr_data;
      end
   end

   assign lvl_to_zero = ~thre & (level_nx == '0);
   assign int_set     = lvl_to_zero | (ier_etbei & ~ier_q & thre);
   assign int_clr     = iir_rd | wr_ok | ~ier_etbei | fifo_clr;

   always_ff @(posedge clk) begin
      if (!rst && !fifo_clr && wr_ok)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pop_q   <= 1'b0;
         ier_q   <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         din     <= '0;
         overrun <= 1'b0;
      end else begin
         pop_q <= pop;
         ier_q <= ier_etbei;
         if (fifo_clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
         end else begin
            if (wr_ok)
               wr_ptr <= wr_ptr_inc;
            if (pop_ok)
               rd_ptr <= rd_ptr_inc;
            level <= level_nx;
            din   <= din_nx;
            if (wr_drop)
               overrun <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         int_state <= INT_IDLE;
         thre_int  <= 1'b0;
      end else begin
         case (int_state)
            INT_IDLE: begin
               if (int_set && !int_clr) begin
                  int_state <= INT_PEND;
                  thre_int  <= 1'b1;
               end
            end
            INT_PEND: begin
               if (int_clr) begin
                  int_state <= INT_IDLE;
                  thre_int  <= 1'b0;
               end
            end
            default: begin
               int_state <= INT_IDLE;
               thre_int  <= 1'b0;
            end
         endcase
      end
   end

endmodule
